// File: rtl/time_set_controller.sv
//==============================================================================
// Module      : time_set_controller
// Description : Button-driven hour/min/sec editor with field blink and a
//               one-cycle commit pulse. Optional macro TIMEOUT_EXIT_EN adds
//               an idle auto-exit back to RUN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module time_set_controller #(
    parameter int BLINK_DIV   = 25_000_000,
    parameter int TIMEOUT_CYC = 1_000_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       load,
    output logic       editing,
    output logic [1:0] edit_field,
    output logic       field_vis
);

    localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);

    // State code doubles as the edit_field value.
    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_SET_HOUR = 2'd1,
        S_SET_MIN  = 2'd2,
        S_SET_SEC  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [4:0]             r_set_hour;
    logic [5:0]             r_set_min;
    logic [5:0]             r_set_sec;
    logic                   r_load;
    logic                   r_editing;
    logic                   r_vis;
    logic [c_BLINK_W-1:0]   r_blink;

    logic                   w_step;
    logic                   w_timeout;
    logic [4:0]             w_hour_step;
    logic [5:0]             w_min_step;
    logic [5:0]             w_sec_step;

    // A step applies only with exactly one of up/down and no mode.
    assign w_step = (btn_up ^ btn_down) & ~btn_mode;

    assign w_hour_step = btn_up ? ((r_set_hour == 5'd23) ? 5'd0  : r_set_hour + 5'd1)
                                : ((r_set_hour == 5'd0)  ? 5'd23 : r_set_hour - 5'd1);
    assign w_min_step  = btn_up ? ((r_set_min == 6'd59)  ? 6'd0  : r_set_min + 6'd1)
                                : ((r_set_min == 6'd0)   ? 6'd59 : r_set_min - 6'd1);
    assign w_sec_step  = btn_up ? ((r_set_sec == 6'd59)  ? 6'd0  : r_set_sec + 6'd1)
                                : ((r_set_sec == 6'd0)   ? 6'd59 : r_set_sec - 6'd1);

`ifdef TIMEOUT_EXIT_EN
    localparam int c_IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYC - 1);

    logic                   w_any;
    logic [c_IDLE_W-1:0]    r_idle;

    assign w_any     = btn_mode | btn_up | btn_down;
    assign w_timeout = (r_state != S_RUN) && !w_any && (r_idle == c_IDLE_LAST);

    always_ff @(posedge clk) begin
        if (reset || r_state == S_RUN || w_any || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_set_hour <= '0;
            r_set_min  <= '0;
            r_set_sec  <= '0;
            r_load     <= 1'b0;
            r_editing  <= 1'b0;
            r_vis      <= 1'b1;
            r_blink    <= '0;
        end else begin
            r_load <= 1'b0;
            if (r_state == S_RUN) begin
                r_vis   <= 1'b1;
                r_blink <= '0;
                if (btn_mode) begin
                    r_set_hour <= cur_hour;
                    r_set_min  <= cur_min;
                    r_set_sec  <= cur_sec;
                    r_state    <= S_SET_HOUR;
                    r_editing  <= 1'b1;
                end
            end else if (btn_mode) begin
                r_vis   <= 1'b1;
                r_blink <= '0;
                case (r_state)
                    S_SET_HOUR: r_state <= S_SET_MIN;
                    S_SET_MIN:  r_state <= S_SET_SEC;
                    default: begin
                        r_state   <= S_RUN;
                        r_editing <= 1'b0;
                        r_load    <= 1'b1;
                    end
                endcase
            end else if (w_timeout) begin
                r_state   <= S_RUN;
                r_editing <= 1'b0;
                r_vis     <= 1'b1;
                r_blink   <= '0;
            end else if (w_step) begin
                r_vis   <= 1'b1;
                r_blink <= '0;
                case (r_state)
                    S_SET_HOUR: r_set_hour <= w_hour_step;
                    S_SET_MIN:  r_set_min  <= w_min_step;
                    default:    r_set_sec  <= w_sec_step;
                endcase
            end else if (r_blink == c_BLINK_LAST) begin
                r_blink <= '0;
                r_vis   <= ~r_vis;
            end else begin
                r_blink <= r_blink + 1'b1;
            end
        end
    end

    assign set_hour   = r_set_hour;
    assign set_min    = r_set_min;
    assign set_sec    = r_set_sec;
    assign load       = r_load;
    assign editing    = r_editing;
    assign edit_field = r_state;
    assign field_vis  = r_vis;

endmodule

`default_nettype wire
